pc_frame_sink: RTL and testbench
================================

Name: pc_frame_sink

Overview:
- Consumes host-to-FPGA 32-bit stream from the write-side FIFO that buffers /dev/xillybus_write_32.
- Stream is parsed as frames: one header word N, then N payload words that must count down N, N-1, ..., 1. This is the same countdown the FPGA-to-host generator produces.
- Checks each payload word and sends one 32-bit status word per frame into the FPGA-to-host FIFO.
- Serves as the loopback/integrity checker for the host-write path.

Parameters:
- MAX_LEN, 1048576: largest accepted N. A header above this is rejected without consuming any payload.

Ports:
- bus_clk  in  1  Xillybus bus clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_empty  in  1  host-to-FPGA FIFO empty.
- in_rd_en  out  1  FIFO read strobe. Standard FIFO: in_data is valid the cycle after in_rd_en.
- in_data  in  32  FIFO dout.
- out_full  in  1  FPGA-to-host FIFO full.
- out_wr_en  out  1  FPGA-to-host FIFO write strobe.
- out_data  out  32  status word.
- busy  out  1  high in any state other than IDLE.
- frames_done  out  16  count of status words written; wraps at 0xFFFF to 0.

Behaviour:
- Reset (async, active-high): state=IDLE. in_rd_en=0, out_wr_en=0, out_data=0, busy=0, frames_done=0. Read-pending flag, counters and error count are cleared. Reset mid-frame discards the partial frame; no status word is sent for it.
- Read pipeline:
  - rd_pend is a registered copy of in_rd_en.
  - in_data is sampled only when rd_pend=1.
  - in_rd_en is never asserted while in_empty=1.
  - Back-to-back reads are allowed (one word per cycle).
- States:
  - IDLE: in_rd_en = !in_empty. Move to HDR on the cycle in_rd_en=1.
  - HDR: in_rd_en=0. Capture N=in_data (rd_pend=1 guaranteed).
    - N==0: status {0, 0x0000, 0x0000}, go to REPORT.
    - N>MAX_LEN: badlen=1, status {1, 0x0000, N[15:0]}, go to REPORT. The next FIFO word is treated as a new header.
    - Otherwise: exp=N, req_left=N, rcv_left=N, errors=0, go to PAY.
  - PAY:
    - in_rd_en = !in_empty && req_left!=0. req_left decrements on each issued read.
    - Each cycle with rd_pend=1: if in_data!=exp, errors increments, saturating at 0x7FFF. exp and rcv_left decrement.
    - When the word with rcv_left==1 is consumed, go to REPORT the next cycle. Exactly N payload words are read; no read is issued past the frame.
    - exp tracks position, not the received value. After a mismatch, the next word is still checked against the position-based expected value.
  - REPORT:
    - out_data holds {badlen, errors[14:0], N[15:0]}; errors=0 for N==0 and badlen cases.
    - out_wr_en = !out_full, one cycle only. On that cycle frames_done increments and the state returns to IDLE.
    - While out_full=1: hold out_data, in_rd_en=0, wait indefinitely.
- out_wr_en is never high for more than one cycle per frame.
- out_data keeps the last status until the next REPORT.
- Widths: exp, req_left, rcv_left are 32-bit unsigned. N is compared to MAX_LEN unsigned. The status word carries only N[15:0].
- in_empty toggling mid-frame only stalls reads. There is no timeout.

Test Plan:
- FIFO words 3,3,2,1 -> exactly 4 reads; one out_wr_en with out_data=0x00000003; frames_done=1; busy low afterwards.
- 4,4,9,2,1 -> out_data=0x00010004. Then 2,2,1 -> 0x00000002 (errors cleared per frame).
- Header 0 followed by 1,1 -> statuses 0x00000000 then 0x00000001; no payload read for the first frame.
- MAX_LEN=16, words 17,1,1 -> 0x80000011, then 0x00000001. The word after the rejected header is parsed as a header.
- Header 3 with out_full held high for 10 cycles after the payload -> out_wr_en stays 0 and in_rd_en stays 0 even with data queued; a single write of 0x00000003 on the first cycle out_full=0.
- Error saturation and reset:
  - Header 40000, all payload words 0 -> status 0x7FFF9C40.
  - Separately, assert reset after 2 of 5 payload words -> outputs zero immediately, no status word; a following frame 1,1 -> 0x00000001 with frames_done=1.

Source files
------------

// File: rtl/pc_frame_sink.sv
// Host-write loopback checker: parses countdown frames from the write FIFO
// and posts one status word per frame to the read FIFO.
module pc_frame_sink #(
  parameter int unsigned MAX_LEN = 1048576
) (
  input  logic        bus_clk,
  input  logic        reset,
  input  logic        in_empty,
  output logic        in_rd_en,
  input  logic [31:0] in_data,
  input  logic        out_full,
  output logic        out_wr_en,
  output logic [31:0] out_data,
  output logic        busy,
  output logic [15:0] frames_done
);

  typedef enum logic [1:0] {IDLE, HDR, PAY, REPORT} state_t;

  localparam logic [31:0] MAX_W = 32'(MAX_LEN);

  state_t      state;
  state_t      state_nxt;
  logic        rd_pend;
  logic        rd_req;
  logic        wr_req;
  logic [15:0] n_lo;
  logic [31:0] exp_word;
  logic [31:0] req_left;
  logic [31:0] rcv_left;
  logic [14:0] errors;
  logic [14:0] err_nxt;

  always_comb begin
    state_nxt = state;
    rd_req    = 1'b0;
    wr_req    = 1'b0;
    err_nxt   = errors;
    if (rd_pend && in_data != exp_word && errors != 15'h7fff)
      err_nxt = errors + 15'd1;
    unique case (state)
      IDLE: begin
        rd_req = !in_empty;
        if (rd_req) state_nxt = HDR;
      end
      HDR: begin
        if (in_data == 32'd0 || in_data > MAX_W)
          state_nxt = REPORT;
        else
          state_nxt = PAY;
      end
      PAY: begin
        rd_req = !in_empty && req_left != 32'd0;
        if (rd_pend && rcv_left == 32'd1) state_nxt = REPORT;
      end
      REPORT: begin
        wr_req = !out_full;
        if (wr_req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Gate strobes with reset so nothing leaks out while held in reset.
  assign in_rd_en  = rd_req & ~reset;
  assign out_wr_en = wr_req & ~reset;
  assign busy      = state != IDLE;

  always_ff @(posedge bus_clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rd_pend     <= 1'b0;
      n_lo        <= '0;
      exp_word    <= '0;
      req_left    <= '0;
      rcv_left    <= '0;
      errors      <= '0;
      out_data    <= '0;
      frames_done <= '0;
    end else begin
      state   <= state_nxt;
      rd_pend <= in_rd_en;
      case (state)
        HDR: begin
          n_lo   <= in_data[15:0];
          errors <= '0;
          if (in_data == 32'd0) begin
            out_data <= '0;
          end else if (in_data > MAX_W) begin
            out_data <= {1'b1, 15'd0, in_data[15:0]};
          end else begin
            exp_word <= in_data;
            req_left <= in_data;
            rcv_left <= in_data;
          end
        end
        PAY: begin
          if (in_rd_en) req_left <= req_left - 32'd1;
          if (rd_pend) begin
            errors   <= err_nxt;
            exp_word <= exp_word - 32'd1;
            rcv_left <= rcv_left - 32'd1;
            if (rcv_left == 32'd1)
              out_data <= {1'b0, err_nxt, n_lo};
          end
        end
        REPORT: begin
          if (out_wr_en) frames_done <= frames_done + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_frame_sink.sv
// Directed bench for pc_frame_sink: FIFO model feeding two instances
// (default and MAX_LEN=16), status scoreboard and protocol monitors.
module tb_pc_frame_sink;

  logic        bus_clk = 1'b0;
  logic        reset   = 1'b1;
  logic        out_full = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] in_data = '0;

  logic        empty_a, empty_b, fifo_empty;
  logic        rd_a, rd_b, wr_a, wr_b, busy_a, busy_b;
  logic [31:0] od_a, od_b;
  logic [15:0] fd_a, fd_b;
  logic        rd_m, wr_m, busy_m;
  logic [31:0] od_m;
  logic [15:0] fd_m;

  logic [31:0] mem [0:65535];
  logic [31:0] stat [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int n_rd = 0;
  int n_wr = 0;
  int viol_rd = 0;
  int viol_wr = 0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 bus_clk = ~bus_clk;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign empty_a = sel ? 1'b1 : fifo_empty;
  assign empty_b = sel ? fifo_empty : 1'b1;
  assign rd_m   = sel ? rd_b : rd_a;
  assign wr_m   = sel ? wr_b : wr_a;
  assign od_m   = sel ? od_b : od_a;
  assign busy_m = sel ? busy_b : busy_a;
  assign fd_m   = sel ? fd_b : fd_a;

  pc_frame_sink dut (
    .bus_clk(bus_clk), .reset(reset),
    .in_empty(empty_a), .in_rd_en(rd_a), .in_data(in_data),
    .out_full(out_full), .out_wr_en(wr_a), .out_data(od_a),
    .busy(busy_a), .frames_done(fd_a)
  );

  pc_frame_sink #(.MAX_LEN(16)) dut_small (
    .bus_clk(bus_clk), .reset(reset),
    .in_empty(empty_b), .in_rd_en(rd_b), .in_data(in_data),
    .out_full(out_full), .out_wr_en(wr_b), .out_data(od_b),
    .busy(busy_b), .frames_done(fd_b)
  );

  always @(posedge bus_clk) begin
    if (rd_m) begin
      if (rd_ptr == wr_ptr) begin
        viol_rd <= viol_rd + 1;
      end else begin
        in_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1;
      end
      n_rd <= n_rd + 1;
    end
    if (wr_m) begin
      if (out_full) viol_wr <= viol_wr + 1;
      stat[n_wr[3:0]] <= od_m;
      n_wr <= n_wr + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    mem[wr_ptr[15:0]] = w;
    wr_ptr++;
  endtask

  task automatic wait_wr(input int target, input int budget);
    int k = 0;
    while (n_wr < target && k < budget) begin
      @(negedge bus_clk);
      k++;
    end
    if (n_wr < target) check("timeout_wr", 32'(n_wr), 32'(target));
  endtask

  task automatic wait_rd(input int target, input int budget);
    int k = 0;
    while (n_rd < target && k < budget) begin
      @(negedge bus_clk);
      k++;
    end
    if (n_rd < target) check("timeout_rd", 32'(n_rd), 32'(target));
  endtask

  initial begin
    int r0;
    int w0;
    repeat (2) @(negedge bus_clk);
    check("rst_rd", 32'(rd_m), 32'd0);
    check("rst_wr", 32'(wr_m), 32'd0);
    check("rst_data", od_m, 32'd0);
    check("rst_busy", 32'(busy_m), 32'd0);
    check("rst_fd", 32'(fd_m), 32'd0);
    reset = 1'b0;
    @(negedge bus_clk);

    r0 = n_rd;
    push(3); push(3); push(2); push(1);
    wait_wr(1, 50);
    check("t1_stat", stat[0], 32'h00000003);
    check("t1_reads", 32'(n_rd - r0), 32'd4);
    check("t1_fd", 32'(fd_m), 32'd1);
    repeat (2) @(negedge bus_clk);
    check("t1_busy", 32'(busy_m), 32'd0);

    push(4); push(4); push(9); push(2); push(1);
    wait_wr(2, 50);
    check("t2_err", stat[1], 32'h00010004);
    push(2); push(2); push(1);
    wait_wr(3, 50);
    check("t2_clr", stat[2], 32'h00000002);

    r0 = n_rd;
    push(0); push(1); push(1);
    wait_wr(5, 50);
    check("t3_zero", stat[3], 32'h00000000);
    check("t3_next", stat[4], 32'h00000001);
    check("t3_reads", 32'(n_rd - r0), 32'd3);
    repeat (2) @(negedge bus_clk);

    r0 = n_rd;
    w0 = n_wr;
    out_full = 1'b1;
    push(3); push(3); push(2); push(1); push(1); push(1);
    repeat (15) @(negedge bus_clk);
    check("t4_nowr", 32'(n_wr), 32'(w0));
    check("t4_reads", 32'(n_rd - r0), 32'd4);
    check("t4_busy", 32'(busy_m), 32'd1);
    check("t4_hold", od_m, 32'h00000003);
    out_full = 1'b0;
    #1;
    check("t4_wr_now", 32'(wr_m), 32'd1);
    @(negedge bus_clk);
    check("t4_one_wr", 32'(n_wr), 32'(w0 + 1));
    check("t4_stat", stat[w0[3:0]], 32'h00000003);
    wait_wr(w0 + 2, 50);
    check("t4_next", stat[(w0 + 1) & 15], 32'h00000001);
    check("t4_fd", 32'(fd_m), 32'd7);

    w0 = n_wr;
    push(40000);
    for (int i = 0; i < 40000; i++) push(0);
    wait_wr(w0 + 1, 41000);
    check("t5_sat", stat[w0[3:0]], 32'h7FFF9C40);
    repeat (2) @(negedge bus_clk);

    sel = 1'b1;
    r0 = n_rd;
    w0 = n_wr;
    push(17); push(1); push(1);
    wait_wr(w0 + 2, 50);
    check("t6_bad", stat[w0[3:0]], 32'h80000011);
    check("t6_next", stat[(w0 + 1) & 15], 32'h00000001);
    check("t6_reads", 32'(n_rd - r0), 32'd3);
    check("t6_fd", 32'(fd_m), 32'd2);
    repeat (2) @(negedge bus_clk);
    sel = 1'b0;

    r0 = n_rd;
    w0 = n_wr;
    push(5); push(5); push(4);
    wait_rd(r0 + 3, 50);
    repeat (2) @(negedge bus_clk);
    check("t7_busy_pre", 32'(busy_m), 32'd1);
    reset = 1'b1;
    #1;
    check("t7_rd", 32'(rd_m), 32'd0);
    check("t7_wr", 32'(wr_m), 32'd0);
    check("t7_data", od_m, 32'd0);
    check("t7_busy", 32'(busy_m), 32'd0);
    check("t7_fd", 32'(fd_m), 32'd0);
    @(negedge bus_clk);
    reset = 1'b0;
    @(negedge bus_clk);
    check("t7_nostat", 32'(n_wr), 32'(w0));
    push(1); push(1);
    wait_wr(w0 + 1, 50);
    check("t7_stat", stat[w0[3:0]], 32'h00000001);
    check("t7_fd1", 32'(fd_m), 32'd1);

    repeat (3) @(negedge bus_clk);
    check("viol_rd", 32'(viol_rd), 32'd0);
    check("viol_wr", 32'(viol_wr), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
